// File: rtl/mmio_timer_display_pkg.sv
// Shared register map, TCON bit positions and hex-to-segment lookup for the
// memory-mapped timer/display peripheral.
package mmio_timer_display_pkg;

   localparam logic [7:0] OFF_TH      = 8'h00;
   localparam logic [7:0] OFF_TL      = 8'h04;
   localparam logic [7:0] OFF_TCON    = 8'h08;
   localparam logic [7:0] OFF_DIGITS  = 8'h10;
   localparam logic [7:0] OFF_SYSTICK = 8'h14;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   // Active-high segments, bit 0 = a ... bit 6 = g.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/mmio_timer_display_seg7_hex_decode.sv
// Combinational hex nibble to active-high a-g segment converter.
module seg7_hex_decode
   import mmio_timer_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/mmio_timer_display.sv
// MMIO slave: reloadable timer with interrupt, free-running systick and a
// four-digit multiplexed seven-segment scanner.
module mmio_timer_display
   import mmio_timer_display_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          SCAN_DIV  = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic        Sel,
   output logic [31:0] Read_data,
   output logic        irq,
   output logic [3:0]  an,
   output logic [7:0]  Cathodes
);

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   logic [31:0] th, tl, systick;
   logic [2:0]  tcon;
   logic [23:0] digits;
   logic [15:0] scan_cnt;
   logic [1:0]  idx;
   logic [7:0]  offset;
   logic [3:0]  nibble, dp, blank;
   logic [6:0]  seg;
   logic        wr_en, wr_th, wr_tl, wr_tcon, wr_digits, tl_max;

   // Bus: a store commits at posedge when Sel && MemWrite; a load is
   // answered combinationally in the same cycle when Sel && MemRead.
   assign Sel       = (Address[31:8] == BASE_ADDR[31:8]);
   assign offset    = Address[7:0] & 8'hFC;
   assign wr_en     = Sel && MemWrite;
   assign wr_th     = wr_en && (offset == OFF_TH);
   assign wr_tl     = wr_en && (offset == OFF_TL);
   assign wr_tcon   = wr_en && (offset == OFF_TCON);
   assign wr_digits = wr_en && (offset == OFF_DIGITS);
   assign tl_max    = (tl == 32'hFFFF_FFFF);
   assign irq       = tcon[TCON_IS];
   assign dp        = digits[19:16];
   assign blank     = digits[23:20];

   always_comb begin
      Read_data = 32'h0;
      if (Sel && MemRead) begin
         case (offset)
            OFF_TH:      Read_data = th;
            OFF_TL:      Read_data = tl;
            OFF_TCON:    Read_data = {29'd0, tcon};
            OFF_DIGITS:  Read_data = {8'd0, digits};
            OFF_SYSTICK: Read_data = systick;
            default:     Read_data = 32'h0;
         endcase
      end
   end

   always_comb begin
      case (idx)
         2'd0:    nibble = digits[3:0];
         2'd1:    nibble = digits[7:4];
         2'd2:    nibble = digits[11:8];
         default: nibble = digits[15:12];
      endcase
   end

   seg7_hex_decode u_dec (
      .nibble (nibble),
      .seg    (seg)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         th       <= 32'h0;
         tl       <= 32'h0;
         tcon     <= 3'b000;
         digits   <= 24'h0;
         systick  <= 32'h0;
         scan_cnt <= 16'h0;
         idx      <= 2'd0;
         an       <= 4'b1111;
         Cathodes <= 8'hFF;
      end else begin
         systick <= systick + 32'd1;
         if (wr_th)
            th <= Write_data;
         // A CPU write to TL overrides counting; reload always uses the old TH.
         if (wr_tl)
            tl <= Write_data;
         else if (tcon[TCON_EN])
            tl <= tl_max ? th : tl + 32'd1;
         if (wr_tcon)
            tcon[TCON_IE:TCON_EN] <= Write_data[TCON_IE:TCON_EN];
         // Status is write-0-to-clear, and a coinciding overflow wins.
         if (tcon[TCON_EN] && tl_max && tcon[TCON_IE])
            tcon[TCON_IS] <= 1'b1;
         else if (wr_tcon && !Write_data[TCON_IS])
            tcon[TCON_IS] <= 1'b0;
         if (wr_digits)
            digits <= Write_data[23:0];
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= 16'h0;
            idx      <= idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 16'd1;
         end
         an       <= blank[idx] ? 4'b1111 : ~(4'b0001 << idx);
         Cathodes <= {~dp[idx], ~seg};
      end
   end

endmodule

// File: tb/tb_mmio_timer_display.sv
// Directed bench for mmio_timer_display with a cycle-level reference model
// and hand-computed literal expectations.
module tb_mmio_timer_display;

   localparam int SCAN_DIV = 4;

   logic        clk, reset;
   logic [31:0] Address, Write_data;
   logic        MemRead, MemWrite;
   logic        Sel;
   logic [31:0] Read_data;
   logic        irq;
   logic [3:0]  an;
   logic [7:0]  Cathodes;

   mmio_timer_display #(.BASE_ADDR(32'h4000_0000), .SCAN_DIV(SCAN_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .Address    (Address),
      .Write_data (Write_data),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Sel        (Sel),
      .Read_data  (Read_data),
      .irq        (irq),
      .an         (an),
      .Cathodes   (Cathodes)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_th, m_tl, m_tick;
   logic        m_en, m_ie, m_is, m_valid;
   logic [23:0] m_digits;
   logic [3:0]  m_an;
   logic [7:0]  m_cath;
   int          m_k;
   logic [45:0] exp_q[$];

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
         4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
         4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
         4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
      endcase
   endfunction

   function automatic logic [32:0] rd_model();
      logic s;
      logic [31:0] d;
      s = (Address[31:8] == 24'h40_0000);
      d = 32'h0;
      if (s && MemRead) begin
         case (Address[7:0] & 8'hFC)
            8'h00: d = m_th;
            8'h04: d = m_tl;
            8'h08: d = {29'd0, m_is, m_ie, m_en};
            8'h10: d = {8'd0, m_digits};
            8'h14: d = m_tick;
            default: d = 32'h0;
         endcase
      end
      return {s, d};
   endfunction

   initial begin
      logic        s, wr, roll;
      logic [7:0]  off;
      logic [31:0] n_tl;
      int          slot;
      m_valid = 1'b0;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_th = 0; m_tl = 0; m_tick = 0; m_en = 0; m_ie = 0; m_is = 0;
            m_digits = 0; m_k = 0; m_an = 4'hF; m_cath = 8'hFF; m_valid = 1'b1;
         end else if (m_valid) begin
            s   = (Address[31:8] == 24'h40_0000);
            wr  = s && MemWrite;
            off = Address[7:0] & 8'hFC;
            slot   = (m_k / SCAN_DIV) % 4;
            m_an   = m_digits[20 + slot] ? 4'hF : ~(4'b0001 << slot);
            m_cath = {~m_digits[16 + slot], ~seg_of(m_digits[slot * 4 +: 4])};
            m_k++;
            roll = m_en && (m_tl == 32'hFFFF_FFFF);
            if (wr && off == 8'h04) n_tl = Write_data;
            else if (m_en)          n_tl = roll ? m_th : m_tl + 1;
            else                    n_tl = m_tl;
            if (roll && m_ie) m_is = 1'b1;
            else if (wr && off == 8'h08 && !Write_data[2]) m_is = 1'b0;
            if (wr && off == 8'h08) begin m_en = Write_data[0]; m_ie = Write_data[1]; end
            if (wr && off == 8'h00) m_th = Write_data;
            if (wr && off == 8'h10) m_digits = Write_data[23:0];
            m_tl   = n_tl;
            m_tick = m_tick + 1;
         end
         if (m_valid) exp_q.push_back({rd_model(), m_is, m_an, m_cath});
      end
   end

   // ---------------- scoreboard compare ----------------
   initial begin
      logic [45:0] e;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_model", {18'd0, Sel, Read_data, irq, an, Cathodes}, {18'd0, e});
         end
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Address = a; Write_data = d; MemWrite = 1'b1; MemRead = 1'b0;
      @(negedge clk);
      MemWrite = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      Address = a; MemRead = 1'b1; MemWrite = 1'b0;
      #1;
      check(name, Read_data, exp);
      @(negedge clk);
      MemRead = 1'b0;
   endtask

   task automatic sync_on(input logic [3:0] target, output bit found);
      logic [3:0] prev;
      found = 1'b0;
      prev = an;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (an == target && prev != target) begin
            found = 1'b1;
            break;
         end
         prev = an;
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [3:0] pat_an[4];
   logic [7:0] pat_cath[4];
   bit         found;

   initial begin
      reset = 1'b1; Address = 0; Write_data = 0; MemRead = 0; MemWrite = 0;
      repeat (2) @(negedge clk);
      check("rst_an", an, 4'b1111);
      check("rst_cath", Cathodes, 8'hFF);
      check("rst_irq", irq, 1'b0);
      rd_check("rst_tcon", 32'h4000_0008, 32'h0);
      rd_check("rst_digits", 32'h4000_0010, 32'h0);
      reset = 1'b0;

      // timer reload and interrupt
      wr(32'h4000_0000, 32'hFFFF_FFF0);
      wr(32'h4000_0004, 32'hFFFF_FFFE);
      wr(32'h4000_0008, 32'h3);
      @(negedge clk);
      rd_check("tl_max", 32'h4000_0004, 32'hFFFF_FFFF);
      check("irq_set", irq, 1'b1);
      rd_check("tl_reload", 32'h4000_0004, 32'hFFFF_FFF0);
      wr(32'h4000_0008, 32'h3);
      check("irq_clear", irq, 1'b0);

      // overflow coinciding with a clear: set wins
      wr(32'h4000_0004, 32'hFFFF_FFFF);
      wr(32'h4000_0008, 32'h3);
      check("irq_set_wins", irq, 1'b1);
      rd_check("tl_reload2", 32'h4000_0004, 32'hFFFF_FFF0);
      wr(32'h4000_0008, 32'h3);
      check("irq_clear2", irq, 1'b0);

      // TL write beats counting
      wr(32'h4000_0004, 32'h5);
      rd_check("tl_write", 32'h4000_0004, 32'h5);
      rd_check("tl_write_inc", 32'h4000_0004, 32'h6);

      // TH write in the reload cycle: old TH loaded
      wr(32'h4000_0004, 32'hFFFF_FFFF);
      wr(32'h4000_0000, 32'h0000_1234);
      rd_check("tl_old_th", 32'h4000_0004, 32'hFFFF_FFF0);
      wr(32'h4000_0008, 32'h0);
      check("irq_off", irq, 1'b0);
      rd_check("th_new", 32'h4000_0000, 32'h0000_1234);
      rd_check("tcon_off", 32'h4000_0008, 32'h0);

      // scanner with decimal point on digit 0
      pat_an[0] = 4'b1110; pat_an[1] = 4'b1101; pat_an[2] = 4'b1011; pat_an[3] = 4'b0111;
      pat_cath[0] = 8'h19; pat_cath[1] = 8'hB0; pat_cath[2] = 8'hA4; pat_cath[3] = 8'hF9;
      wr(32'h4000_0010, 32'h0001_1234);
      sync_on(4'b1110, found);
      check("scan_sync", found, 1'b1);
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < SCAN_DIV; c++) begin
            check("scan_an", an, pat_an[d]);
            check("scan_cath", Cathodes, pat_cath[d]);
            @(negedge clk);
         end
      end
      check("scan_wrap_an", an, 4'b1110);
      check("scan_wrap_cath", Cathodes, 8'h19);

      // blank mask on digits 0 and 2
      pat_an[0] = 4'b1101; pat_an[1] = 4'b1111; pat_an[2] = 4'b0111; pat_an[3] = 4'b1111;
      wr(32'h4000_0010, 32'h0050_00AB);
      sync_on(4'b1101, found);
      check("blank_sync", found, 1'b1);
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < SCAN_DIV; c++) begin
            check("blank_an", an, pat_an[d]);
            if (d == 0) check("blank_cath_a", Cathodes, 8'h88);
            if (d == 2) check("blank_cath_0", Cathodes, 8'hC0);
            @(negedge clk);
         end
      end

      // unmapped offset and out-of-window address
      wr(32'h4000_0020, 32'hDEAD_BEEF);
      Address = 32'h4000_0020; MemRead = 1'b1;
      #1;
      check("hole_sel", Sel, 1'b1);
      check("hole_data", Read_data, 32'h0);
      @(negedge clk);
      wr(32'h1000_0010, 32'hFFFF_FFFF);
      Address = 32'h1000_0010; MemRead = 1'b1;
      #1;
      check("out_sel", Sel, 1'b0);
      check("out_data", Read_data, 32'h0);
      @(negedge clk);
      rd_check("digits_kept", 32'h4000_0010, 32'h0050_00AB);
      wr(32'h4000_0014, 32'h0);
      Address = 32'h4000_0014; MemRead = 1'b1;
      repeat (3) @(negedge clk);
      MemRead = 1'b0;

      // reset mid-scan
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_an", an, 4'b1111);
      check("mid_rst_cath", Cathodes, 8'hFF);
      check("mid_rst_irq", irq, 1'b0);
      rd_check("mid_rst_tl", 32'h4000_0004, 32'h0);
      rd_check("mid_rst_digits", 32'h4000_0010, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_an", an, 4'b1110);
      check("post_rst_cath", Cathodes, 8'hC0);
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_timer_display.md
Name: mmio_timer_display

Overview:
- Memory-mapped peripheral slave that sits directly downstream of the CPU's MEM stage, on the same address, write-data and control bus as the data memory.
- Provides a reloadable 32-bit timer with an interrupt flag, a free-running systick counter, and a 4-digit multiplexed 7-segment display scanner.
- The top level muxes Read_data into the load path when Sel is high and routes an/Cathodes to the board pins.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the 256-byte peripheral window; only bits [31:8] are compared.
- SCAN_DIV, 40, clk cycles per digit slot (1 ms per digit at 40 kHz); legal range 2..65535.

Ports:
- clk  in  1  pipeline clock (the divided 40 kHz clock)
- reset  in  1  synchronous, active-high
- Address  in  32  byte address from EX/MEM ALU result
- Write_data  in  32  store data
- MemRead  in  1  load strobe
- MemWrite  in  1  store strobe
- Sel  out  1  combinational: Address[31:8] == BASE_ADDR[31:8]
- Read_data  out  32  combinational read data
- irq  out  1  registered interrupt request, equal to TCON[2]
- an  out  4  registered digit enables, active-low
- Cathodes  out  8  registered segments, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Clock and reset: one clock is used. reset is synchronous and active-high; it is sampled on posedge clk only.
- Reset values:
  - TH, TL, TCON, DIGITS, SYSTICK, scan counter and digit index all 0.
  - an = 4'b1111, Cathodes = 8'hFF, irq = 0.
- Register map (offset = Address[7:0]; Address[1:0] are ignored):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: [0] enable, [1] irq enable, [2] irq status; bits [31:3] read 0.
  - 0x10 DIGITS: [15:0] four hex nibbles (digit0 = [3:0]), [19:16] decimal-point enables, [23:20] blank mask; other bits read 0.
  - 0x14 SYSTICK: read-only; increments every cycle and wraps at 2^32.
  - Any other offset reads 0 and ignores writes.
- Read path:
  - Zero-latency combinational read.
  - Read_data = selected register when Sel && MemRead, else 32'h0.
- Write path: takes effect at posedge when Sel && MemWrite. Writes to SYSTICK are ignored.
- Timer, each cycle with TCON[0]=1:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and TCON[2] <= 1 when TCON[1]=1.
  - Otherwise TL <= TL + 1.
- Simultaneous-event priorities:
  - A CPU write to TL beats the increment or reload in the same cycle.
  - A TH write in the reload cycle does not affect that reload; the old TH is loaded.
  - TCON[2] is write-0-to-clear; writing 1 has no effect.
  - An overflow set coinciding with a clear leaves TCON[2] = 1 (set wins).
  - Writes to TCON[1:0] take effect next cycle. A TCON write that sets enable does not itself count.
- irq: a register, so it follows TCON[2] with no extra delay (it is the same flop or its copy).
- Scanner:
  - scan_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→0.
  - an/Cathodes are registered from the current index and DIGITS, so they change one cycle after an index or DIGITS update.
  - an = ~(4'b0001 << idx), except 4'b1111 when blank[idx]=1.
  - Cathodes = {~dp[idx], ~seg(nibble[idx])}; hex 0–F uses the standard a–g patterns.
- Reset mid-operation:
  - reset wins over every write and count in that cycle.
  - The scan restarts at digit 0 and count 0.

Decomposition:
- Shared package (or header):
  - Register offset constants: TH, TL, TCON, DIGITS, SYSTICK.
  - TCON bit indices.
  - 16-entry hex-to-7-segment table, active-high a–g.
- Sub-module seg7_hex_decode: combinational 4-bit to 7-bit converter, instantiated once on the selected nibble. The timer and bus logic stay in the top module.

Test Plan:
- Reset, then read 0x4000_0008 and 0x4000_0010 → Read_data 0; an=4'b1111, Cathodes=8'hFF, irq=0.
- Write TH=FFFF_FFF0, TL=FFFF_FFFE, TCON=3 → TL reads FFFF_FFFF one cycle after enable. The next cycle TL=FFFF_FFF0 and irq=1. Write TCON=3 (bit2=0) → irq=0 the next cycle.
- Overflow coincides with a TCON write of 3'b011 → irq stays 1. A TL write of 5 during an enabled count → TL reads 5 the next cycle, then 6.
- Write DIGITS=32'h0001_1234 with SCAN_DIV=4 → the pattern sequence is (an=1110, Cathodes=0x99 for "4" with dp=0x19), then an=1101 "3"=0xB0, an=1011 "2"=0xA4, an=0111 "1"=0xF9. Each digit lasts 4 cycles, then the sequence wraps.
- Blank mask: DIGITS=32'h0050_00AB → the slots for digits 0 and 2 show an=4'b1111; digit1 shows "A"=0x88.
- Address 0x4000_0020 write → no state change, Read_data=0, Sel=1. Address 0x1000_0010 → Sel=0, Read_data=0. Assert reset mid-scan → next cycle idx=0 and outputs are at reset values.
